// File: rtl/dense_layer.sv
// Fully-connected layer: output_vector = W * input_vector + bias_vector in signed
// Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS. One MAC per cycle, weights streamed row-major from
// an external synchronous ROM with one cycle of read latency.
module dense_layer #(
   parameter int unsigned WIDTH      = 128,
   parameter int unsigned IN_WIDTH   = 64,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH+8,
   localparam int unsigned AddrW = (WIDTH*IN_WIDTH > 1) ? $clog2(WIDTH*IN_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] input_vector [0:IN_WIDTH-1],
   input  logic [DATA_WIDTH-1:0] bias_vector  [0:WIDTH-1],
   output logic                  w_rd,
   output logic [AddrW-1:0]      w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic [DATA_WIDTH-1:0] output_vector [0:WIDTH-1],
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned RowW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ColW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int unsigned ProdW = 2*DATA_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] Half = ACC_WIDTH'(1) <<< (FRAC_BITS-1);

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StDrain, StWrite, StDone} state_e;

   state_e state_q, state_d;
   logic [RowW-1:0] row_q;
   logic [ColW-1:0] col_q, pcol_q;
   logic pvld_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] x_q   [0:IN_WIDTH-1];
   logic [DATA_WIDTH-1:0] b_q   [0:WIDTH-1];
   logic [DATA_WIDTH-1:0] out_q [0:WIDTH-1];

   logic last_col, last_row;
   logic signed [ProdW-1:0] w_ext, x_ext, prod;
   logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, rsum, rshift;
   logic [DATA_WIDTH-1:0] sat;

   assign last_col = (col_q == ColW'(IN_WIDTH-1));
   assign last_row = (row_q == RowW'(WIDTH-1));
   assign output_vector = out_q;

   // Product of the weight arriving now with the activation issued one cycle earlier
   always_comb begin
      w_ext    = {{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data};
      x_ext    = {{DATA_WIDTH{x_q[pcol_q][DATA_WIDTH-1]}}, x_q[pcol_q]};
      prod     = w_ext * x_ext;
      prod_ext = {{(ACC_WIDTH-ProdW){prod[ProdW-1]}}, prod};
      bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){b_q[row_q][DATA_WIDTH-1]}},
                  b_q[row_q], {FRAC_BITS{1'b0}}};
   end

   // Round half-up, drop back to Q.F and saturate to the data width
   always_comb begin
      rsum   = acc_q + Half;
      rshift = rsum >>> FRAC_BITS;
      if ((&rshift[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|rshift[ACC_WIDTH-1:DATA_WIDTH-1])) begin
         sat = rshift[DATA_WIDTH-1:0];
      end else if (rshift[ACC_WIDTH-1]) begin
         sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; enable only matters in IDLE and DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable) state_d = StLoad;
         StLoad:  state_d = StMac;
         StMac:   if (last_col) state_d = StDrain;
         StDrain: state_d = StWrite;
         StWrite: state_d = last_row ? StDone : StLoad;
         StDone:  if (!enable) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      busy   = (state_q == StLoad) || (state_q == StMac) ||
               (state_q == StDrain) || (state_q == StWrite);
      done   = (state_q == StDone);
      w_rd   = (state_q == StMac);
      w_addr = AddrW'(row_q) * AddrW'(IN_WIDTH) + AddrW'(col_q);
   end

   // Operand capture at the start edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < IN_WIDTH; i++) x_q[i] <= '0;
         for (int i = 0; i < WIDTH; i++) b_q[i] <= '0;
      end else if (state_q == StIdle && enable) begin
         x_q <= input_vector;
         b_q <= bias_vector;
      end
   end

   // Row/column counters, read pipeline tracking and accumulator
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q  <= '0;
         col_q  <= '0;
         pcol_q <= '0;
         pvld_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         pvld_q <= (state_q == StMac);
         pcol_q <= col_q;
         if (pvld_q) acc_q <= acc_q + prod_ext;
         else if (state_q == StLoad) acc_q <= bias_ext;
         case (state_q)
            StIdle: begin
               if (enable) begin
                  row_q <= '0;
                  col_q <= '0;
               end
            end
            StMac: col_q <= last_col ? '0 : col_q + 1'b1;
            StWrite: begin
               col_q <= '0;
               if (!last_row) row_q <= row_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Result registers; rows keep old values until their WRITE cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < WIDTH; i++) out_q[i] <= '0;
      end else if (state_q == StWrite) begin
         out_q[row_q] <= sat;
      end
   end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer with WIDTH=2, IN_WIDTH=4, Q8.8 data.
module tb_dense_layer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] x    [0:3];
   logic [15:0] b    [0:1];
   logic [15:0] outv [0:1];
   logic [15:0] rom  [0:7];
   logic        w_rd;
   logic [2:0]  w_addr;
   logic [15:0] w_data = '0;
   logic        busy, done;

   int n_vec = 0;
   int n_err = 0;
   int addr_log[$];
   int lat;

   dense_layer #(
      .WIDTH(2), .IN_WIDTH(4), .DATA_WIDTH(16), .FRAC_BITS(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .input_vector(x), .bias_vector(b),
      .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
      .output_vector(outv), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous weight ROM, one cycle read latency
   always @(posedge clk) begin
      if (w_rd) begin
         w_data <= rom[w_addr];
         addr_log.push_back(int'(w_addr));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Start a run and wait for done; optionally drop enable and scramble inputs mid-run
   task automatic run(input int drop_at, output int latency);
      bit seen = 0;
      latency = 0;
      addr_log.delete();
      @(negedge clk);
      enable = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk);
         #1;
         latency++;
         if (drop_at != 0 && latency == drop_at) begin
            enable = 1'b0;
            x = '{default: 16'h1234};
            b = '{default: 16'h4321};
         end
         if (done) seen = 1;
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic release_enable();
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_done", {busy, done}, 32'd0);
   endtask

   task automatic set_basic();
      x   = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
      b   = '{16'h0000, 16'hFF00};
      rom = '{16'h0100, 16'h0100, 16'h0100, 16'h0100,
              16'h0080, 16'h0000, 16'h0000, 16'h0000};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset  = 1'b0;
      enable = 1'b0;
      x   = '{default: 16'h0};
      b   = '{default: 16'h0};
      rom = '{default: 16'h0};
      #1;
      check("rst_out0", outv[0], 32'h0);
      check("rst_out1", outv[1], 32'h0);
      check("rst_busy", busy, 32'd0);
      check("rst_done", done, 32'd0);
      check("rst_w_rd", w_rd, 32'd0);
      check("rst_w_addr", w_addr, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Basic
      set_basic();
      run(0, lat);
      check("basic_latency", lat, 32'd14);
      check("basic_out0", outv[0], 32'h0280);
      check("basic_out1", outv[1], 32'hFF80);
      check("addr_count", addr_log.size(), 32'd8);
      for (int i = 0; i < addr_log.size() && i < 8; i++) check("addr_seq", addr_log[i], i);
      @(posedge clk);
      #1;
      check("done_held", done, 32'd1);
      release_enable();

      // Saturation
      x   = '{default: 16'h7FFF};
      b   = '{default: 16'h0000};
      rom = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
              16'h8000, 16'h8000, 16'h8000, 16'h8000};
      run(0, lat);
      check("sat_pos", outv[0], 32'h7FFF);
      check("sat_neg", outv[1], 32'h8000);
      release_enable();

      // Rounding half-up
      x   = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
      b   = '{default: 16'h0000};
      rom = '{16'h0080, 16'h0000, 16'h0000, 16'h0000,
              16'hFF80, 16'h0000, 16'h0000, 16'h0000};
      run(0, lat);
      check("rnd_up", outv[0], 32'h0001);
      check("rnd_neg_half", outv[1], 32'h0000);
      release_enable();

      // Enable dropped mid-run, inputs changed after start
      set_basic();
      run(3, lat);
      check("drop_latency", lat, 32'd14);
      check("drop_out0", outv[0], 32'h0280);
      check("drop_out1", outv[1], 32'hFF80);
      @(posedge clk);
      #1;
      check("done_pulse", done, 32'd0);
      check("drop_idle_busy", busy, 32'd0);

      // Async reset during row 1 MAC
      set_basic();
      found = 0;
      @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1;
         if (w_rd && w_addr >= 3'd5) found = 1;
      end
      check("reached_row1_mac", 32'(found), 32'd1);
      #2;
      reset  = 1'b0;
      enable = 1'b0;
      #1;
      check("arst_out0", outv[0], 32'h0);
      check("arst_out1", outv[1], 32'h0);
      check("arst_busy", busy, 32'd0);
      check("arst_w_rd", w_rd, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("stay_idle", busy, 32'd0);
      run(0, lat);
      check("rerun_out0", outv[0], 32'h0280);
      check("rerun_out1", outv[1], 32'hFF80);
      release_enable();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dense_layer.md
# dense_layer

Fully-connected layer stage that computes `output_vector = W·input_vector + bias_vector` in signed Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS fixed point. It sits directly upstream of the `sigmoid` activation block: `output_vector` connects to `sigmoid.input_vector` and `done` drives `sigmoid.enable`. Weights are read row-major from an external synchronous ROM through a single multiply-accumulate unit, one MAC per cycle.

## Interface
Parameters:
- `WIDTH`, 128: number of output neurons; matches the sigmoid `WIDTH`.
- `IN_WIDTH`, 64: number of input elements.
- `DATA_WIDTH`, 16: width of every data word, signed two's complement.
- `FRAC_BITS`, 8: fractional bits of every data word.
- `ACC_WIDTH`, 2*DATA_WIDTH+8: accumulator width, signed; must be at least 2*DATA_WIDTH + clog2(IN_WIDTH) + 1.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level start request.
- `input_vector`  in  [DATA_WIDTH-1:0] x [0:IN_WIDTH-1]  activations; latched at start.
- `bias_vector`  in  [DATA_WIDTH-1:0] x [0:WIDTH-1]  biases; latched at start.
- `w_rd`  out  1  weight ROM read strobe.
- `w_addr`  out  clog2(WIDTH*IN_WIDTH)  weight address, `row*IN_WIDTH+col`.
- `w_data`  in  DATA_WIDTH  weight data; valid exactly 1 cycle after `w_rd`.
- `output_vector`  out  [DATA_WIDTH-1:0] x [0:WIDTH-1]  registered results.
- `busy`  out  1  high in LOAD/MAC/DRAIN/WRITE.
- `done`  out  1  high in DONE.

## Operation
- Reset (`reset`=0, asynchronous): state=IDLE; all `output_vector` words=0; `done`=0; `busy`=0; `w_rd`=0; `w_addr`=0; accumulator, row, col and pipeline-valid flag cleared.
- IDLE: if `enable`=1 at an edge, latch `input_vector` and `bias_vector`, set row=0 and col=0, go to LOAD.
- LOAD: set acc = sign-extended `bias[row]` << FRAC_BITS (Q.2F alignment); go to MAC.
- MAC: drive `w_rd`=1 and `w_addr`=row*IN_WIDTH+col; increment col. After the col=IN_WIDTH-1 issue, go to DRAIN.
- Pipelined accumulate: on the edge after each `w_rd` cycle, acc += `w_data` * x[col issued] (full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH).
- DRAIN: no read (`w_rd`=0); the last product is accumulated; go to WRITE.
- WRITE: `output_vector[row]` = sat(( acc + 2^(FRAC_BITS-1) ) >>> FRAC_BITS). Rounding is half-up toward +inf. Saturation limits are 0x8000 and 0x7FFF (for DATA_WIDTH=16). If row=WIDTH-1, go to DONE; otherwise row++, col=0, go to LOAD.
- DONE: `done`=1. Stay while `enable`=1; return to IDLE when `enable`=0.
- `enable` is ignored outside IDLE and DONE. Dropping it mid-computation does not abort; the block passes through DONE for one cycle, giving a one-cycle `done` pulse.
- Changes to `input_vector` or `bias_vector` after the start edge have no effect.
- `output_vector` words hold their values until overwritten by the next run's WRITE or cleared by reset. During a run, rows not yet written keep the previous run's values.

## Timing
- Per row: 1 LOAD + IN_WIDTH MAC + 1 DRAIN + 1 WRITE = IN_WIDTH+3 cycles.
- Start edge (IDLE→LOAD) to first edge with `done`=1: WIDTH*(IN_WIDTH+3) edges.
- `output_vector[r]` updates on the WRITE edge of row r.
- `w_addr` is sequential 0..WIDTH*IN_WIDTH-1, with `w_rd` gaps of 3 cycles between rows.
- An asynchronous reset asserted at any point, including mid-MAC, gives immediate reset values. After release, the block is in IDLE and needs a fresh `enable` edge to start.
- `enable` held high through DONE→IDLE→start: a new run starts only after `enable` has been low for at least 1 cycle. DONE exits only on `enable`=0.

## Test plan
Bench configuration: WIDTH=2, IN_WIDTH=4, DATA_WIDTH=16, FRAC_BITS=8. The ROM model returns data 1 cycle after `w_rd`.
- Basic: x=[0x0100,0x0200,0xFF00,0x0080]; W row0=[0x0100 ×4], bias0=0; W row1=[0x0080,0,0,0], bias1=0xFF00. Required: out=[0x0280,0xFF80]; `done` on edge 14 after start.
- Saturation: x and W all 0x7FFF gives out0=0x7FFF. W row1 all 0x8000 with x all 0x7FFF gives out1=0x8000.
- Rounding: x0=0x0001, W row0=[0x0080,0,0,0] gives 0x0001. W row1=[0xFF80,0,0,0] gives 0x0000. Both biases 0.
- Enable drop: deassert `enable` 3 cycles after start. Required: run completes, correct outputs, `done` high for exactly 1 cycle, then IDLE.
- Async reset mid-MAC (row 1): outputs=0, `busy`=0, `w_rd`=0 immediately without a clock edge. A new run then gives the Basic results.
- Hand-off: `done` drives sigmoid `enable` with input 0x0000 → sigmoid output 0x0080. `w_addr` sequence checked as 0..7.
